// File: rtl/dsfq_pkg.sv
// Shared helpers for the DSFQ gate family.
// Counter width, popcount and default hold.
package dsfq_pkg;

  localparam int DSFQ_HOLD = 4;
  localparam int POP_W = 64;

  // Width of a down-counter that must hold the value n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int popcount(
    input logic [POP_W-1:0] v
  );
    int c;
    c = 0;
    for (int i = 0; i < POP_W; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/dsfq_hold_cell.sv
// One DSFQ input: edge detect and hold window.
// A pulse stays live for HOLD edges unless consumed.
module dsfq_hold_cell
  import dsfq_pkg::*;
#(
  parameter int HOLD = DSFQ_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic armed,
  input  logic a,
  input  logic fire,
  output logic p,
  output logic live,
  output logic held
);

  localparam int CW = cnt_w(HOLD);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t HOLD_V = cnt_t'(HOLD);
  localparam cnt_t ONE = cnt_t'(1);

  logic a_prev;
  cnt_t cnt;

  assign p    = armed & (a ^ a_prev);
  assign held = (cnt != '0);
  assign live = p | (cnt > ONE);

  // Track the input level even while disarmed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) a_prev <= 1'b0;
    else     a_prev <= a;
  end

  // Clear on fire wins over a fresh load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (fire) begin
      cnt <= '0;
    end else if (p) begin
      cnt <= HOLD_V;
    end else if (held) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/dsfq_and_n.sv
// N-input DSFQ coincidence gate, K-of-N.
// Toggle-encoded in/out with output delay.
module dsfq_and_n
  import dsfq_pkg::*;
#(
  parameter int N          = 2,
  parameter int K          = N,
  parameter int HOLD       = DSFQ_HOLD,
  parameter int OUT_DELAY  = 2,
  parameter int ARM_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic         err_clr,
  output logic         q,
  output logic [N-1:0] held,
  output logic         err,
  output logic         armed
);

  localparam int AW = cnt_w(ARM_CYCLES);
  localparam logic [AW-1:0] ARM_V =
    AW'(ARM_CYCLES);

  logic [AW-1:0]        arm_cnt;
  logic [N-1:0]         p;
  logic [N-1:0]         live;
  logic [POP_W-1:0]     live_ext;
  logic                 fire;
  logic [OUT_DELAY-1:0] dly;

  assign armed    = (arm_cnt == ARM_V);
  assign live_ext = POP_W'(live);
  assign fire     = armed &
    (popcount(live_ext) >= K);

  for (genvar i = 0; i < N; i++) begin : g_cell
    dsfq_hold_cell #(
      .HOLD(HOLD)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .armed(armed),
      .a    (a[i]),
      .fire (fire),
      .p    (p[i]),
      .live (live[i]),
      .held (held[i])
    );
  end

  // Count settling edges after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 1'b1;
  end

  // Every fire travels the line, none merged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly <= '0;
    end else begin
      dly[0] <= fire;
      for (int i = 1; i < OUT_DELAY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  // One output toggle per delivered fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= q ^ dly[OUT_DELAY-1];
  end

  // A pulse onto a still-held input is an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             err <= 1'b0;
    else if (|(p & held)) err <= 1'b1;
    else if (err_clr)    err <= 1'b0;
  end

endmodule
